cs161_multicycle_ctrl: RTL and testbench
========================================

// Module: cs161_multicycle_ctrl
// PURPOSE
//  Multi-cycle MIPS control FSM that replaces single-cycle decode in the cs161 CPU.
//  Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives datapath strobes.
//  Waits on a variable-latency memory handshake with a timeout, decodes funct to ALU control,
//  and counts retired instructions. Sits between cpumemory/cpu_registers/alu and the top level.
// PARAMETERS
//  ALU_CTRL_W   4    width of alu_ctrl output
//  CNT_W        32   width of retired-instruction counter
//  MEM_TIMEOUT  15   max cycles to wait for mem_ready before error (1..255)
// PORTS
//  clk          in   1           clock, all state updates on posedge
//  rst          in   1           synchronous reset, active-high
//  instr_op     in   6           opcode field from instruction register
//  funct        in   6           funct field from instruction register
//  mem_ready    in   1           memory completes current access this cycle
//  pc_write     out  1           unconditional PC load
//  pc_write_cond out 1           PC load if ALU zero (beq)
//  pc_source    out  2           00 ALU result, 01 branch target, 10 jump target
//  i_or_d       out  1           memory address: 0 PC, 1 ALU out
//  mem_read     out  1           memory read request
//  mem_write    out  1           memory write request
//  ir_write     out  1           latch instruction register
//  reg_dst      out  1           1 rd, 0 rt
//  mem_to_reg   out  1           1 memory data, 0 ALU out
//  reg_write    out  1           register file write
//  alu_src_a    out  1           0 PC, 1 rs
//  alu_src_b    out  2           00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  alu_ctrl     out  ALU_CTRL_W  ALU operation code
//  instr_done   out  1           one-cycle pulse on final cycle of each instruction
//  retired      out  CNT_W       count of completed instructions
//  err_code     out  2           00 ok, 01 illegal opcode, 10 illegal funct, 11 mem timeout
// BEHAVIOUR
//  States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, IMM_EXEC,
//   IMM_WB, JUMP, ERROR. Moore decode from state_q; strobes qualified by mem_ready where noted.
//  Reset: state FETCH, retired 0, err_code 00, wait counter 0; all outputs 0 during rst cycle.
//  FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_ctrl=0010; ir_write,pc_write
//   only in the cycle mem_ready=1, then -> DECODE. Otherwise hold.
//  DECODE: alu_src_b=11 (branch target precompute). op 000000->R_EXEC, 100011/101011->MEM_ADDR,
//   000100->BRANCH, 001000->IMM_EXEC, else ERROR(01).
//  R_EXEC: alu_src_a=1, alu_src_b=00; funct 100000 add 0010, 100010 sub 0110, 100100 and 0000,
//   100101 or 0001, 100111 nor 1100, 101010 slt 0111; unknown funct -> ERROR(10), else R_WB.
//  R_WB: reg_dst=1, reg_write=1, instr_done=1 -> FETCH.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_ctrl=0010; lw->MEM_RD, sw->MEM_WR.
//  MEM_RD: mem_read=1, i_or_d=1; on mem_ready -> MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1,
//   reg_dst=0, instr_done=1 -> FETCH. MEM_WR: mem_write=1, i_or_d=1; on mem_ready
//   instr_done=1 -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_ctrl=0110, pc_write_cond=1, pc_source=01,
//   instr_done=1 -> FETCH.
//  IMM_EXEC: alu_src_a=1, alu_src_b=10, alu_ctrl=0010 -> IMM_WB (reg_write=1, reg_dst=0, done).
//  Wait counter: counts consecutive mem_ready=0 cycles in FETCH/MEM_RD/MEM_WR, clears on
//   mem_ready or state change; reaching MEM_TIMEOUT -> ERROR(11), no strobe issued.
//  ERROR: all strobes 0, err_code sticky, stays until rst. rst mid-access aborts, no write.
//  retired increments on instr_done, wraps modulo 2^CNT_W. Unused alu_ctrl bits 0.
// CONFIGURATION
//  CS161_JUMP_EN defined: opcode 000010 in DECODE -> JUMP (pc_write=1, pc_source=10,
//   instr_done=1) -> FETCH. Undefined: opcode 000010 -> ERROR(01); pc_source never 10.
// STRUCTURE
//  Package cs161_mc_pkg: opcode/funct/alu_ctrl localparams, state encoding (4-bit), err codes.
//  Sub-module cs161_alu_decode: combinational funct -> {alu_ctrl, funct_illegal}.
// TESTING
//  add (op 0, funct 100000), mem_ready=1 in FETCH -> 4 cycles, R_WB reg_write=1, retired=1.
//  lw with mem_ready delayed 3 cycles in MEM_RD -> mem_read held 4 cycles, done at cycle 8.
//  mem_ready held 0 in FETCH for 15 cycles -> err_code=11, strobes 0 until rst.
//  op 000000 funct 111111 -> ERROR(10); op 000010 -> JUMP if CS161_JUMP_EN else ERROR(01).
//  beq -> BRANCH pc_write_cond=1, alu_ctrl=0110, pc_source=01; sw -> no reg_write.
//  rst asserted in MEM_WR with mem_ready=0 -> next cycle FETCH, retired=0, mem_write=0.

Source files
------------

// File: rtl/cs161_mc_pkg.sv
// Shared definitions for the cs161 multi-cycle control unit.
// Contents: MIPS opcode/funct field values, 4-bit ALU operation codes,
// datapath mux select values, error codes, the 4-bit FSM state encoding,
// and a helper that identifies the states that wait on the memory handshake.
// Optional feature macro used by the control unit: CS161_JUMP_EN.
package cs161_mc_pkg;

   // Opcode field values
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type funct field values
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU operation codes
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // ALU B-operand select
   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_BRANCH = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Error codes
   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_OPCODE  = 2'b01;
   localparam logic [1:0] ERR_FUNCT   = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_IMM_EXEC = 4'd9,
      S_IMM_WB   = 4'd10,
      S_JUMP     = 4'd11,
      S_ERROR    = 4'd12
   } state_t;

   // States that hold an outstanding memory access and are subject to timeout
   function automatic logic is_mem_wait(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/cs161_alu_decode.sv
// R-type funct decoder for the cs161 multi-cycle control unit.
// Ports:
//   funct         in  6  funct field of the current instruction
//   alu_code      out 4  ALU operation code (0000 when funct is illegal)
//   funct_illegal out 1  funct is not one of add/sub/and/or/nor/slt
module cs161_alu_decode
   import cs161_mc_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alu_code,
   output logic       funct_illegal
);

   always_comb begin
      alu_code      = ALU_AND;
      funct_illegal = 1'b0;
      case (funct)
         FN_ADD:  alu_code = ALU_ADD;
         FN_SUB:  alu_code = ALU_SUB;
         FN_AND:  alu_code = ALU_AND;
         FN_OR:   alu_code = ALU_OR;
         FN_NOR:  alu_code = ALU_NOR;
         FN_SLT:  alu_code = ALU_SLT;
         default: funct_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/cs161_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM for the cs161 CPU. Sequences each instruction
// through FETCH/DECODE/EXEC/MEM/WB, drives the datapath strobes, waits on a
// variable-latency memory handshake with a timeout, and counts retired
// instructions.
// Optional feature macro: CS161_JUMP_EN (adds the J instruction; without it
// opcode 000010 is an illegal opcode and pc_source never reads 10).
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   instr_op, funct             opcode and funct fields from the IR
//   mem_ready                   memory finishes the current access this cycle
//   pc_write, pc_write_cond     PC load (unconditional / on ALU zero)
//   pc_source                   00 ALU result, 01 branch target, 10 jump target
//   i_or_d, mem_read, mem_write memory address select and requests
//   ir_write                    latch instruction register
//   reg_dst, mem_to_reg         register file destination / data select
//   reg_write                   register file write
//   alu_src_a, alu_src_b        ALU operand selects
//   alu_ctrl                    ALU operation code (upper bits zero)
//   instr_done                  pulse on the final cycle of each instruction
//   retired                     completed-instruction count (wraps)
//   err_code                    00 ok, 01 opcode, 10 funct, 11 memory timeout
module cs161_multicycle_ctrl
   import cs161_mc_pkg::*;
#(
   parameter int ALU_CTRL_W  = 4,
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 15
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [5:0]            instr_op,
   input  logic [5:0]            funct,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  pc_write_cond,
   output logic [1:0]            pc_source,
   output logic                  i_or_d,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  ir_write,
   output logic                  reg_dst,
   output logic                  mem_to_reg,
   output logic                  reg_write,
   output logic                  alu_src_a,
   output logic [1:0]            alu_src_b,
   output logic [ALU_CTRL_W-1:0] alu_ctrl,
   output logic                  instr_done,
   output logic [CNT_W-1:0]      retired,
   output logic [1:0]            err_code
);

   // Index of the last tolerated not-ready cycle; the next one trips the timeout
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic [1:0]       err_code_q, err_code_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic [3:0] dec_code;
   logic       funct_illegal;

   // Ungated strobe values decoded from the current state
   logic                  pc_write_raw, pc_write_cond_raw, i_or_d_raw, mem_read_raw;
   logic                  mem_write_raw, ir_write_raw, reg_dst_raw, mem_to_reg_raw;
   logic                  reg_write_raw, alu_src_a_raw, instr_done_raw;
   logic [1:0]            pc_source_raw, alu_src_b_raw;
   logic [3:0]            alu_code;
   logic [ALU_CTRL_W-1:0] alu_ctrl_wide;

   cs161_alu_decode u_alu_decode (
      .funct         (funct),
      .alu_code      (dec_code),
      .funct_illegal (funct_illegal)
   );

   // Moore decode; only the handshake-completion strobes look at mem_ready
   always_comb begin
      pc_write_raw      = 1'b0;
      pc_write_cond_raw = 1'b0;
      pc_source_raw     = PCSRC_ALU;
      i_or_d_raw        = 1'b0;
      mem_read_raw      = 1'b0;
      mem_write_raw     = 1'b0;
      ir_write_raw      = 1'b0;
      reg_dst_raw       = 1'b0;
      mem_to_reg_raw    = 1'b0;
      reg_write_raw     = 1'b0;
      alu_src_a_raw     = 1'b0;
      alu_src_b_raw     = SRCB_RT;
      alu_code          = ALU_AND;
      instr_done_raw    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read_raw  = 1'b1;
            alu_src_b_raw = SRCB_FOUR;
            alu_code      = ALU_ADD;
            ir_write_raw  = mem_ready;
            pc_write_raw  = mem_ready;
         end
         S_DECODE: begin
            // Branch target is precomputed while the opcode is examined
            alu_src_b_raw = SRCB_IMM_SH;
            alu_code      = ALU_ADD;
         end
         S_R_EXEC: begin
            alu_src_a_raw = 1'b1;
            alu_src_b_raw = SRCB_RT;
            alu_code      = dec_code;
         end
         S_R_WB: begin
            reg_dst_raw    = 1'b1;
            reg_write_raw  = 1'b1;
            instr_done_raw = 1'b1;
         end
         S_MEM_ADDR, S_IMM_EXEC: begin
            alu_src_a_raw = 1'b1;
            alu_src_b_raw = SRCB_IMM;
            alu_code      = ALU_ADD;
         end
         S_MEM_RD: begin
            mem_read_raw = 1'b1;
            i_or_d_raw   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write_raw  = 1'b1;
            mem_to_reg_raw = 1'b1;
            instr_done_raw = 1'b1;
         end
         S_MEM_WR: begin
            mem_write_raw  = 1'b1;
            i_or_d_raw     = 1'b1;
            instr_done_raw = mem_ready;
         end
         S_BRANCH: begin
            alu_src_a_raw     = 1'b1;
            alu_src_b_raw     = SRCB_RT;
            alu_code          = ALU_SUB;
            pc_write_cond_raw = 1'b1;
            pc_source_raw     = PCSRC_BRANCH;
            instr_done_raw    = 1'b1;
         end
         S_IMM_WB: begin
            reg_write_raw  = 1'b1;
            instr_done_raw = 1'b1;
         end
`ifdef CS161_JUMP_EN
         S_JUMP: begin
            pc_write_raw   = 1'b1;
            pc_source_raw  = PCSRC_JUMP;
            instr_done_raw = 1'b1;
         end
`endif
         default: ;  // ERROR: everything quiet
      endcase
   end

   always_comb begin
      alu_ctrl_wide      = '0;
      alu_ctrl_wide[3:0] = alu_code;
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      err_code_d = err_code_q;
      retired_d  = retired_q + CNT_W'(instr_done_raw);
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (instr_op)
               OP_RTYPE:     state_d = S_R_EXEC;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_IMM_EXEC;
`ifdef CS161_JUMP_EN
               OP_J:         state_d = S_JUMP;
`else
               OP_J: begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_OPCODE;
               end
`endif
               default: begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_OPCODE;
               end
            endcase
         end
         S_R_EXEC: begin
            if (funct_illegal) begin
               state_d    = S_ERROR;
               err_code_d = ERR_FUNCT;
            end else begin
               state_d = S_R_WB;
            end
         end
         S_MEM_ADDR: state_d = (instr_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
         S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
         S_IMM_EXEC: state_d = S_IMM_WB;
`ifdef CS161_JUMP_EN
         S_JUMP:     state_d = S_FETCH;
`endif
         S_R_WB, S_MEM_WB, S_BRANCH, S_IMM_WB: state_d = S_FETCH;
         default: ;  // ERROR holds until reset
      endcase

      // Count consecutive not-ready cycles; any exit from the wait clears it
      if (is_mem_wait(state_q) && !mem_ready) begin
         if (wait_cnt_q == TIMEOUT_LAST) begin
            state_d    = S_ERROR;
            err_code_d = ERR_TIMEOUT;
         end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
         err_code_q <= ERR_OK;
         retired_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         err_code_q <= err_code_d;
         retired_q  <= retired_d;
      end
   end

   // Everything reads zero while reset is held, so an aborted access never writes
   assign pc_write      = pc_write_raw & ~rst;
   assign pc_write_cond = pc_write_cond_raw & ~rst;
   assign pc_source     = rst ? 2'b00 : pc_source_raw;
   assign i_or_d        = i_or_d_raw & ~rst;
   assign mem_read      = mem_read_raw & ~rst;
   assign mem_write     = mem_write_raw & ~rst;
   assign ir_write      = ir_write_raw & ~rst;
   assign reg_dst       = reg_dst_raw & ~rst;
   assign mem_to_reg    = mem_to_reg_raw & ~rst;
   assign reg_write     = reg_write_raw & ~rst;
   assign alu_src_a     = alu_src_a_raw & ~rst;
   assign alu_src_b     = rst ? 2'b00 : alu_src_b_raw;
   assign alu_ctrl      = rst ? '0 : alu_ctrl_wide;
   assign instr_done    = instr_done_raw & ~rst;
   assign retired       = rst ? '0 : retired_q;
   assign err_code      = rst ? ERR_OK : err_code_q;

endmodule

// File: tb/tb_cs161_multicycle_ctrl.sv
// Self-checking bench for cs161_multicycle_ctrl. Each instruction is run as a
// transaction with chosen fetch/data memory latencies; a per-instruction model
// derived from the instruction-class rules predicts the completion cycle, the
// number of cycles each strobe is active and the resulting error code.
module tb_cs161_multicycle_ctrl;

   localparam int TMO = 15;
`ifdef CS161_JUMP_EN
   localparam bit JUMP_EN = 1'b1;
`else
   localparam bit JUMP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  instr_op = '0;
   logic [5:0]  funct = '0;
   logic        mem_ready = 1'b0;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done;
   logic [1:0]  pc_source, alu_src_b, err_code;
   logic [3:0]  alu_ctrl;
   logic [31:0] retired;
   logic [18:0] strobe_vec;

   int tests = 0;
   int fails = 0;
   int exp_retired = 0;

   typedef struct {
      int cycles; int err; int rd; int wr; int regw; int irw; int pcw; int pcwc;
      int m2r; int rdst; int iod; int dec; int bsrc; int jsrc; int alu;
   } exp_t;

   cs161_multicycle_ctrl #(.ALU_CTRL_W(4), .CNT_W(32), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .instr_op(instr_op), .funct(funct), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
      .instr_done(instr_done), .retired(retired), .err_code(err_code)
   );

   assign strobe_vec = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                        ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                        alu_ctrl, instr_done};

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int obs, input int expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic int r_code(input logic [5:0] fn);
      case (fn)
         6'b100000: return 2;   // add
         6'b100010: return 6;   // sub
         6'b100100: return 0;   // and
         6'b100101: return 1;   // or
         6'b100111: return 12;  // nor
         6'b101010: return 7;   // slt
         default:   return -1;
      endcase
   endfunction

   // Expected transaction summary. cycles is the 1-based cycle (counted from the
   // first fetch cycle) on which instr_done or a nonzero err_code first shows.
   function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                  input int lf, input int ld);
      exp_t e;
      int base;
      e.cycles = 0; e.err = 0; e.rd = 0; e.wr = 0; e.regw = 0; e.irw = 0; e.pcw = 0;
      e.pcwc = 0; e.m2r = 0; e.rdst = 0; e.iod = 0; e.dec = 0; e.bsrc = 0; e.jsrc = 0;
      e.alu = -1;
      if (lf >= TMO) begin
         e.cycles = TMO + 1; e.err = 3; e.rd = TMO;
         return e;
      end
      base = lf + 1;  // fetch length
      e.rd = base; e.irw = 1; e.pcw = 1; e.dec = 1;
      if (op == 6'b000000) begin
         e.cycles = base + 3;
         if (r_code(fn) < 0) e.err = 2;
         else begin e.regw = 1; e.rdst = 1; e.alu = r_code(fn); end
      end else if (op == 6'b100011 || op == 6'b101011) begin
         if (ld >= TMO) begin
            e.cycles = base + 3 + TMO; e.err = 3; e.iod = TMO;
            if (op == 6'b100011) e.rd += TMO; else e.wr = TMO;
         end else if (op == 6'b100011) begin
            e.cycles = base + ld + 4; e.rd += ld + 1; e.iod = ld + 1; e.regw = 1; e.m2r = 1;
         end else begin
            e.cycles = base + ld + 3; e.wr = ld + 1; e.iod = ld + 1;
         end
      end else if (op == 6'b000100) begin
         e.cycles = base + 2; e.pcwc = 1; e.bsrc = 1; e.alu = 6;
      end else if (op == 6'b001000) begin
         e.cycles = base + 3; e.regw = 1;
      end else if (op == 6'b000010 && JUMP_EN) begin
         e.cycles = base + 2; e.pcw = 2; e.jsrc = 1;
      end else begin
         e.cycles = base + 2; e.err = 1;
      end
      return e;
   endfunction

   // Entered just after a posedge; leaves just after a posedge with rst low.
   task automatic do_reset();
      rst = 1'b1;
      mem_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_outputs_zero", int'(strobe_vec != 0 || err_code != 0 || retired != 0), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      mem_ready = 1'b0;
      #1;
      exp_retired = 0;
      chk("post_rst_retired", int'(retired), 0);
      chk("post_rst_err", int'(err_code), 0);
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                            input int lf, input int ld);
      exp_t e;
      int cyc, rd, wr, regw, irw, pcw, pcwc, m2r, rdst, iod, dec, bsrc, jsrc, alu_seen;
      int fw, dw;
      bit term;
      e = model(op, fn, lf, ld);
      instr_op = op; funct = fn;
      cyc = 0; rd = 0; wr = 0; regw = 0; irw = 0; pcw = 0; pcwc = 0; m2r = 0; rdst = 0;
      iod = 0; dec = 0; bsrc = 0; jsrc = 0; alu_seen = -1; fw = 0; dw = 0; term = 1'b0;
      while (!term && cyc < 100) begin
         cyc++;
         // Complete the presented access after its latency; otherwise random noise
         if (mem_read || mem_write) begin
            if (!i_or_d) begin mem_ready = (fw == lf); fw++; end
            else         begin mem_ready = (dw == ld); dw++; end
         end else begin
            mem_ready = 1'($urandom);
         end
         @(negedge clk);
         rd += int'(mem_read); wr += int'(mem_write); regw += int'(reg_write);
         irw += int'(ir_write); pcw += int'(pc_write); pcwc += int'(pc_write_cond);
         m2r += int'(mem_to_reg); rdst += int'(reg_write & reg_dst); iod += int'(i_or_d);
         dec += int'(alu_src_b == 2'b11); bsrc += int'(pc_source == 2'b01);
         jsrc += int'(pc_source == 2'b10);
         if (alu_src_a && alu_src_b == 2'b00) alu_seen = int'(alu_ctrl);
         if (instr_done || err_code != 2'b00) term = 1'b1;
         else begin @(posedge clk); #1; end
      end
      $display("[TB] op=%b funct=%b lf=%0d ld=%0d cycles=%0d err=%0d", op, fn, lf, ld, cyc,
               err_code);
      chk("cycles", cyc, e.cycles);
      chk("err_code", int'(err_code), e.err);
      chk("mem_read_cycles", rd, e.rd);
      chk("mem_write_cycles", wr, e.wr);
      chk("reg_write_cycles", regw, e.regw);
      chk("ir_write_cycles", irw, e.irw);
      chk("pc_write_cycles", pcw, e.pcw);
      chk("pc_write_cond_cycles", pcwc, e.pcwc);
      chk("mem_to_reg_cycles", m2r, e.m2r);
      chk("reg_dst_rd_cycles", rdst, e.rdst);
      chk("i_or_d_cycles", iod, e.iod);
      chk("decode_cycles", dec, e.dec);
      chk("pc_source_branch", bsrc, e.bsrc);
      chk("pc_source_jump", jsrc, e.jsrc);
      if (e.alu >= 0) chk("alu_ctrl", alu_seen, e.alu);
      @(posedge clk); #1;
      if (e.err == 0 && err_code == 2'b00) begin
         exp_retired++;
         chk("retired", int'(retired), exp_retired);
      end else begin
         repeat (3) begin
            mem_ready = 1'($urandom);
            @(negedge clk);
            chk("error_strobes_zero", int'(strobe_vec != 0), 0);
            chk("error_sticky", int'(err_code), e.err);
            @(posedge clk); #1;
         end
         do_reset();
      end
   endtask

   logic [5:0] ops  [10] = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100,
                             6'b001000, 6'b000010, 6'b111111, 6'b010101, 6'b000000};
   logic [5:0] fns  [6]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                             6'b101010};

   initial begin
      logic [5:0] op, fn;
      int lf, ld;

      // Reset and initial FETCH outputs
      do_reset();
      chk("reset_fetch_mem_read", int'(mem_read), 1);
      chk("reset_fetch_i_or_d", int'(i_or_d), 0);
      chk("reset_fetch_alu_src_b", int'(alu_src_b), 1);
      chk("reset_fetch_alu_ctrl", int'(alu_ctrl), 2);
      chk("reset_fetch_ir_write", int'(ir_write), 0);

      // Directed instruction mix
      run_instr(6'b000000, 6'b100000, 0, 0);   // add, 4 cycles
      run_instr(6'b100011, 6'b000000, 0, 3);   // lw, done at cycle 8
      run_instr(6'b101011, 6'b000000, 1, 2);   // sw
      run_instr(6'b000100, 6'b000000, 0, 0);   // beq
      run_instr(6'b001000, 6'b000000, 2, 0);   // addi
      for (int i = 1; i < 6; i++) run_instr(6'b000000, fns[i], 0, 0);
      run_instr(6'b000000, 6'b100000, TMO - 1, 0);  // last cycle before timeout
      run_instr(6'b100011, 6'b000000, 0, TMO - 1);

      // Reset while a store waits for memory
      instr_op = 6'b101011; mem_ready = 1'b1;
      @(negedge clk); @(posedge clk); #1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("sw_write_pending", int'(mem_write), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_in_mem_wr_write", int'(mem_write), 0);
      chk("rst_in_mem_wr_done", int'(instr_done), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      exp_retired = 0;
      $display("[TB] reset during sw: mem_write=%0d mem_read=%0d retired=%0d", mem_write,
               mem_read, retired);
      chk("after_rst_mem_write", int'(mem_write), 0);
      chk("after_rst_fetch", int'(mem_read), 1);
      chk("after_rst_i_or_d", int'(i_or_d), 0);
      chk("after_rst_retired", int'(retired), 0);

      // Error cases
      run_instr(6'b000000, 6'b111111, 0, 0);   // illegal funct
      run_instr(6'b000010, 6'b000000, 0, 0);   // jump or illegal opcode
      run_instr(6'b000000, 6'b100000, TMO, 0); // fetch timeout
      run_instr(6'b101011, 6'b000000, 0, TMO); // store timeout
      run_instr(6'b000000, 6'b100000, 0, 0);

      // Randomised instruction stream
      for (int n = 0; n < 40; n++) begin
         op = ops[$urandom_range(0, 9)];
         if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
         else fn = fns[$urandom_range(0, 5)];
         lf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO - 1, TMO + 1))
                                          : int'($urandom_range(0, 4));
         ld = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO - 1, TMO + 1))
                                          : int'($urandom_range(0, 4));
         run_instr(op, fn, lf, ld);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
